fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of write requesters (2..8).
REQ-002 The block SHALL have parameter DSIZE, default 8, giving the data width and matching the FIFO write data width.
REQ-003 The block SHALL have parameter BURST, default 4, giving the maximum beats per grant (1..15).
REQ-004 Port i_clk, input, 1 bit: the single clock, which is the FIFO write clock; all state changes on its rising edge.
REQ-005 Port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port i_req_valid, input, NREQ bits: per-requester data valid.
REQ-007 Port i_req_data, input, NREQ*DSIZE bits: requester k data occupies bits [k*DSIZE +: DSIZE].
REQ-008 Port o_req_ready, output, NREQ bits: per-requester beat accepted this cycle.
REQ-009 Port o_wr, output, 1 bit: FIFO write strobe.
REQ-010 Port o_wdata, output, DSIZE bits: FIFO write data.
REQ-011 Port i_wfull, input, 1 bit: FIFO full flag from the write domain.
REQ-012 Port o_grant, output, NREQ bits: one-hot current owner, all zero when idle.
REQ-013 Port o_beat_cnt, output, 16 bits: total beats written, wrapping modulo 2^16.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-015 In IDLE with i_req_valid != 0, the block SHALL select the first valid requester in circular order starting at last_owner+1, load o_grant one-hot, clear the burst counter and go to GRANT on the next edge.
REQ-016 In IDLE with i_req_valid == 0, the block SHALL stay in IDLE with o_grant = 0.
REQ-017 In GRANT, the transfer condition SHALL be xfer = i_req_valid[owner] & ~i_wfull.
REQ-018 o_wr SHALL equal xfer, combinationally.
REQ-019 o_req_ready[owner] SHALL equal xfer; all other ready bits SHALL be 0.
REQ-020 o_wdata SHALL equal the owner's data slice in GRANT, and 0 in IDLE.
REQ-021 Minimum latency SHALL be: valid seen in IDLE at edge N, first write accepted in the cycle after edge N+1.
REQ-022 On each xfer the block SHALL increment the burst counter (4-bit) and o_beat_cnt by 1.
REQ-023 The block SHALL release the grant (go to IDLE, o_grant = 0, last_owner = owner) when xfer occurs with burst counter == BURST-1.
REQ-024 The block SHALL also release the grant when i_req_valid[owner] = 0 in GRANT, regardless of i_wfull.
REQ-025 While i_wfull = 1 and the owner stays valid, the block SHALL hold the grant and the burst count unchanged, with o_wr = 0 and no timeout.
REQ-026 After a release, one IDLE bubble cycle SHALL precede the next grant; there SHALL be no back-to-back grant in the same cycle.
REQ-027 With a single active requester, that requester SHALL be re-granted after each bubble.
REQ-028 Valid bits of non-owners SHALL be ignored during GRANT; a requester SHALL hold its data stable while valid and not ready.
REQ-029 o_beat_cnt SHALL wrap from 16'hFFFF to 0 without a flag.

Reset
REQ-030 While i_rst = 1 the block SHALL force, asynchronously: state IDLE, o_grant = 0, burst counter = 0, o_beat_cnt = 0, last_owner = NREQ-1 (so requester 0 has first priority).
REQ-031 While i_rst = 1 or in the cycle it deasserts, o_wr and o_req_ready SHALL be 0.
REQ-032 Reset mid-burst SHALL abandon the burst; no partial state SHALL survive.

Verification
REQ-033 Single requester 0 valid for 6 beats, BURST=4, i_wfull=0 -> 4 writes, 1 idle cycle, 2 writes; o_beat_cnt = 6.
REQ-034 All 4 requesters continuously valid, BURST=4 -> grant order 0,1,2,3,0; each owns 4 beats; one bubble between grants.
REQ-035 Owner 2 mid-burst, i_wfull held high for 5 cycles -> o_wr = 0, o_grant stays 4'b0100, count frozen; the burst resumes when i_wfull drops.
REQ-036 Owner 1 drops valid after 2 beats with requester 3 valid -> release, IDLE one cycle, grant 4'b1000.
REQ-037 i_rst pulsed during a burst with beat count 37 -> o_grant = 0, o_beat_cnt = 0, o_wr = 0 immediately; requester 0 wins first after reset.
REQ-038 Force o_beat_cnt to 16'hFFFF, then one write -> o_beat_cnt = 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the FIFO write port.
// Latency: none; pure signal grouping.
// Backpressure: carried by i_wfull toward the arbiter and o_req_ready toward requesters.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ*DSIZE-1:0] i_req_data;
    logic [NREQ-1:0]       o_req_ready;
    logic                  o_wr;
    logic [DSIZE-1:0]      o_wdata;
    logic                  i_wfull;
    logic [NREQ-1:0]       o_grant;
    logic [15:0]           o_beat_cnt;

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_data, i_wfull,
        output o_req_ready, o_wr, o_wdata, o_grant, o_beat_cnt
    );

    // Requester / FIFO side
    modport master (
        output i_req_valid, i_req_data, i_wfull,
        input  o_req_ready, o_wr, o_wdata, o_grant, o_beat_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter giving NREQ requesters bursts of up to BURST beats into one FIFO write port.
// Latency: grant one edge after valid is seen in IDLE; one IDLE bubble between consecutive grants.
// Backpressure: i_wfull holds the owner (no write, burst count frozen, no timeout); ready is per beat.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    last_q, last_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [3:0]       burst_q, burst_d;
    logic [15:0]      beat_cnt_q;

    logic [OW-1:0]    pick_idx;
    logic             pick_vld;
    logic             owner_vld;
    logic             xfer;
    logic             last_beat;
    logic [DSIZE-1:0] wdata;

    // Owner still presenting data; grant_q is one-hot in GRANT and zero in IDLE
    assign owner_vld = (state_q == GRANT) && (|(bus.i_req_valid & grant_q));
    assign xfer      = owner_vld && !bus.i_wfull;
    assign last_beat = (burst_q == 4'(BURST - 1));

    assign bus.o_wr        = xfer;
    assign bus.o_req_ready = grant_q & {NREQ{xfer}};
    assign bus.o_grant     = grant_q;
    assign bus.o_beat_cnt  = beat_cnt_q;
    assign bus.o_wdata     = wdata;

    // Pick the first valid requester in circular order starting just after the last owner
    always_comb begin
        logic [OW-1:0] cand;
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = OW'((int'(last_q) + i) % NREQ);
            if (!pick_vld && bus.i_req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Route the owner's data slice to the FIFO; zero while idle
    always_comb begin
        wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (state_q == GRANT && owner_q == OW'(k)) begin
                wdata = bus.i_req_data[k*DSIZE +: DSIZE];
            end
        end
    end

    // Next-state logic: grant from IDLE, release on a dropped valid or the final beat
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    burst_d = 4'd0;
                end
            end
            GRANT: begin
                if (!owner_vld) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (xfer) begin
                    burst_d = burst_q + 4'd1;
                    if (last_beat) begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // FSM and arbitration state; reset leaves requester 0 with first priority
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            grant_q <= '0;
            burst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
        end
    end

    // Running count of accepted beats, wraps silently
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_cnt_q <= 16'd0;
        end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a transaction-level reference model.
// Latency: model predicts every cycle's outputs from requester queues and owner/burst bookkeeping.
// Backpressure: i_wfull driven directly, randomly in the soak phase.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus: each requester has a number of beats still to send and its current data word
    int               rem [NREQ];
    logic [DSIZE-1:0] dat [NREQ];
    logic             wfull_drv;

    // Reference model: owner index (-1 when nobody owns), beats in this grant, last owner, total beats
    int m_owner, m_beats, m_last, m_total;

    logic [NREQ-1:0]  exp_grant, exp_ready;
    logic             exp_wr;
    logic [DSIZE-1:0] exp_wdata;

    task automatic drive();
        logic [NREQ-1:0]       v;
        logic [NREQ*DSIZE-1:0] d;
        for (int k = 0; k < NREQ; k++) begin
            v[k] = (rem[k] > 0);
            d[k*DSIZE +: DSIZE] = dat[k];
        end
        bus.i_req_valid = v;
        bus.i_req_data  = d;
        bus.i_wfull     = wfull_drv;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = NREQ - 1;
        m_total = 0;
    endtask

    task automatic model_comb();
        exp_grant = '0;
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_wdata = '0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            exp_wdata = dat[m_owner];
            if (rem[m_owner] > 0 && !wfull_drv) begin
                exp_wr = 1'b1;
                exp_ready[m_owner] = 1'b1;
            end
        end
    endtask

    // Advance one clock: model follows the arbitration rules, requesters consume accepted beats
    task automatic tick();
        int k;
        model_comb();
        @(posedge clk);
        if (m_owner < 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                k = (m_last + i) % NREQ;
                if (m_owner < 0 && rem[k] > 0) begin
                    m_owner = k;
                    m_beats = 0;
                end
            end
        end else if (rem[m_owner] == 0) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (exp_wr) begin
            m_total = (m_total + 1) % 65536;
            m_beats++;
            rem[m_owner]--;
            dat[m_owner] = DSIZE'($urandom);
            if (m_beats == BURST) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        #1 drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) rem[k] = 0;
        wfull_drv = 1'b0;
        drive();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) rem[k] = 2;
        drive();
        model_reset();
        #3;
        n_checks++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", bus.o_grant); end
        n_checks++; if (bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %b want 0", bus.o_wr); end
        n_checks++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", bus.o_req_ready); end
        n_checks++; if (bus.o_beat_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_beat_cnt got %h want 0000", bus.o_beat_cnt); end
        n_checks++; if (bus.o_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h want 00", bus.o_wdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL reset_release_wr got %b want 0", bus.o_wr); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", bus.o_grant); end
    endtask

    task automatic test_single_burst();
        logic [11:0] wrs;
        do_reset();
        rem[0] = 6;
        drive();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            model_comb();
            wrs[c] = bus.o_wr;
            n_checks++; if (bus.o_grant !== exp_grant) begin n_fail++; $display("FAIL single_grant c%0d got %b want %b", c, bus.o_grant, exp_grant); end
            n_checks++; if (bus.o_wdata !== exp_wdata) begin n_fail++; $display("FAIL single_wdata c%0d got %h want %h", c, bus.o_wdata, exp_wdata); end
            tick();
        end
        n_checks++; if (wrs !== 12'h0DE) begin n_fail++; $display("FAIL single_wr_pattern got %b want %b", wrs, 12'h0DE); end
        n_checks++; if (bus.o_beat_cnt !== 16'd6) begin n_fail++; $display("FAIL single_beat_cnt got %0d want 6", bus.o_beat_cnt); end
    endtask

    task automatic test_round_robin();
        int order [$];
        int want [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] prev;
        do_reset();
        for (int k = 0; k < NREQ; k++) rem[k] = 100;
        drive();
        prev = '0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            model_comb();
            if (prev == '0 && bus.o_grant != '0) order.push_back(onehot_idx(bus.o_grant));
            prev = bus.o_grant;
            n_checks++; if (bus.o_grant !== exp_grant) begin n_fail++; $display("FAIL rr_grant c%0d got %b want %b", c, bus.o_grant, exp_grant); end
            n_checks++; if (bus.o_req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready c%0d got %b want %b", c, bus.o_req_ready, exp_ready); end
            tick();
        end
        n_checks++;
        if (order.size() < 5) begin
            n_fail++; $display("FAIL rr_order_len got %0d want 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (order[i] != want[i]) begin
                    n_fail++; $display("FAIL rr_order idx%0d got %0d want %0d", i, order[i], want[i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_wfull_stall();
        int saved;
        bit reached;
        do_reset();
        rem[2] = 10;
        drive();
        reached = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_owner == 2 && m_beats == 2) begin reached = 1; break; end
            @(negedge clk);
            tick();
        end
        n_checks++; if (!reached) begin n_fail++; $display("FAIL stall_reach got timeout want owner 2 mid-burst"); end
        wfull_drv = 1'b1;
        drive();
        saved = m_total;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL stall_wr c%0d got %b want 0", c, bus.o_wr); end
            n_checks++; if (bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL stall_grant c%0d got %b want 0100", c, bus.o_grant); end
            n_checks++; if (bus.o_beat_cnt !== 16'(saved)) begin n_fail++; $display("FAIL stall_cnt c%0d got %0d want %0d", c, bus.o_beat_cnt, saved); end
            tick();
        end
        wfull_drv = 1'b0;
        drive();
        @(negedge clk);
        n_checks++; if (bus.o_wr !== 1'b1) begin n_fail++; $display("FAIL stall_resume_wr got %b want 1", bus.o_wr); end
        n_checks++; if (bus.o_wdata !== dat[2]) begin n_fail++; $display("FAIL stall_resume_wdata got %h want %h", bus.o_wdata, dat[2]); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.o_grant !== 4'b0100 || bus.o_wr !== 1'b1) begin n_fail++; $display("FAIL stall_last_beat got grant %b wr %b want 0100 1", bus.o_grant, bus.o_wr); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL stall_release got %b want 0000", bus.o_grant); end
        tick();
    endtask

    task automatic test_drop_valid();
        logic [3:0] want_g [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
        logic       want_w [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        rem[1] = 2;
        rem[3] = 5;
        drive();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (bus.o_grant !== want_g[c]) begin n_fail++; $display("FAIL drop_grant c%0d got %b want %b", c, bus.o_grant, want_g[c]); end
            n_checks++; if (bus.o_wr !== want_w[c]) begin n_fail++; $display("FAIL drop_wr c%0d got %b want %b", c, bus.o_wr, want_w[c]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        bit reached;
        do_reset();
        for (int k = 0; k < NREQ; k++) rem[k] = 30;
        drive();
        reached = 0;
        for (int c = 0; c < 200; c++) begin
            if (m_total == 37 && m_owner >= 0) begin reached = 1; break; end
            @(negedge clk);
            model_comb();
            n_checks++; if (bus.o_beat_cnt !== 16'(m_total)) begin n_fail++; $display("FAIL midrst_cnt c%0d got %0d want %0d", c, bus.o_beat_cnt, m_total); end
            tick();
        end
        n_checks++; if (!reached) begin n_fail++; $display("FAIL midrst_reach got timeout want 37 beats mid-burst"); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL midrst_grant got %b want 0000", bus.o_grant); end
        n_checks++; if (bus.o_beat_cnt !== 16'h0000) begin n_fail++; $display("FAIL midrst_cnt0 got %0d want 0", bus.o_beat_cnt); end
        n_checks++; if (bus.o_wr !== 1'b0) begin n_fail++; $display("FAIL midrst_wr got %b want 0", bus.o_wr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_release_ready got %b want 0000", bus.o_req_ready); end
        tick();
        @(negedge clk);
        n_checks++; if (bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant got %b want 0001", bus.o_grant); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.beat_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.beat_cnt_q;
        m_total = 65535;
        n_checks++; if (bus.o_beat_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", bus.o_beat_cnt); end
        rem[2] = 1;
        drive();
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            model_comb();
            n_checks++; if (bus.o_wr !== exp_wr) begin n_fail++; $display("FAIL wrap_wr c%0d got %b want %b", c, bus.o_wr, exp_wr); end
            tick();
        end
        n_checks++; if (bus.o_beat_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_cnt got %h want 0000", bus.o_beat_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            model_comb();
            n_checks++; if (bus.o_grant !== exp_grant) begin n_fail++; $display("FAIL rand_grant c%0d got %b want %b", c, bus.o_grant, exp_grant); end
            n_checks++; if (bus.o_wr !== exp_wr) begin n_fail++; $display("FAIL rand_wr c%0d got %b want %b", c, bus.o_wr, exp_wr); end
            n_checks++; if (bus.o_req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c%0d got %b want %b", c, bus.o_req_ready, exp_ready); end
            n_checks++; if (bus.o_wdata !== exp_wdata) begin n_fail++; $display("FAIL rand_wdata c%0d got %h want %h", c, bus.o_wdata, exp_wdata); end
            n_checks++; if (bus.o_beat_cnt !== 16'(m_total)) begin n_fail++; $display("FAIL rand_cnt c%0d got %0d want %0d", c, bus.o_beat_cnt, m_total); end
            for (int k = 0; k < NREQ; k++) begin
                if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = int'($urandom_range(1, 12));
            end
            wfull_drv = ($urandom_range(0, 3) == 0);
            drive();
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wfull_drv = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            rem[k] = 0;
            dat[k] = DSIZE'($urandom);
        end
        drive();
        model_reset();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_wfull_stall();
        test_drop_valid();
        test_reset_mid_burst();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
